// File: rtl/rv_flush_ctrl.sv
// Control-hazard flush controller: squashes IF/ID and ID/EX and redirects the PC on a
// taken branch or jump resolved in EX, traps misaligned targets and counts branch events.
module rv_flush_ctrl (
  input  logic        clk,
  input  logic        rstn,
  input  logic        EX_valid_i,
  input  logic        EX_branch_i,
  input  logic        EX_taken_i,
  input  logic        EX_jump_i,
  input  logic [31:0] EX_pc_i,
  input  logic [31:0] EX_target_i,
  input  logic        PC_write_i,
  input  logic        cnt_clr_i,
  output logic        IF_flush_o,
  output logic        ID_flush_o,
  output logic        PC_redirect_o,
  output logic [31:0] PC_target_o,
  output logic        misalign_o,
  output logic [31:0] misalign_pc_o,
  output logic [31:0] branch_cnt_o,
  output logic [31:0] redirect_cnt_o
);

  typedef enum logic [1:0] {StIdle, StFlush, StHold} state_e;

  state_e      r_state;
  logic        r_if_flush;
  logic        r_id_flush;
  logic        r_redirect;
  logic [31:0] r_target;
  logic        r_misalign;
  logic [31:0] r_misalign_pc;
  logic [31:0] r_branch_cnt;
  logic [31:0] r_redirect_cnt;

  logic w_idle;
  logic w_req;
  logic w_aligned;
  logic w_branch_evt;
  logic w_redirect_evt;

  // EX is only trusted in IDLE; in FLUSH/HOLD it carries wrong-path instructions.
  assign w_idle         = (r_state == StIdle);
  assign w_req          = EX_valid_i & ((EX_branch_i & EX_taken_i) | EX_jump_i);
  assign w_aligned      = (EX_target_i[1:0] == 2'b00);
  assign w_branch_evt   = w_idle & EX_valid_i & EX_branch_i;
  assign w_redirect_evt = w_idle & w_req & w_aligned;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state        <= StIdle;
      r_if_flush     <= 1'b0;
      r_id_flush     <= 1'b0;
      r_redirect     <= 1'b0;
      r_target       <= 32'h0;
      r_misalign     <= 1'b0;
      r_misalign_pc  <= 32'h0;
      r_branch_cnt   <= 32'h0;
      r_redirect_cnt <= 32'h0;
    end else begin
      r_misalign <= 1'b0;
      case (r_state)
        StIdle: begin
          if (w_req) begin
            if (w_aligned) begin
              r_state    <= StFlush;
              r_if_flush <= 1'b1;
              r_id_flush <= 1'b1;
              r_redirect <= 1'b1;
              r_target   <= EX_target_i;
            end else begin
              r_misalign    <= 1'b1;
              r_misalign_pc <= EX_pc_i;
            end
          end
        end
        StFlush: begin
          if (PC_write_i) begin
            r_state    <= StIdle;
            r_if_flush <= 1'b0;
            r_id_flush <= 1'b0;
            r_redirect <= 1'b0;
          end else begin
            r_state <= StHold;
          end
        end
        StHold: begin
          // Keep the redirect asserted until the stalled PC actually takes it.
          if (PC_write_i) begin
            r_state    <= StIdle;
            r_if_flush <= 1'b0;
            r_id_flush <= 1'b0;
            r_redirect <= 1'b0;
          end
        end
        default: begin
          r_state    <= StIdle;
          r_if_flush <= 1'b0;
          r_id_flush <= 1'b0;
          r_redirect <= 1'b0;
        end
      endcase

      if (cnt_clr_i) begin
        r_branch_cnt   <= 32'h0;
        r_redirect_cnt <= 32'h0;
      end else begin
        if (w_branch_evt)   r_branch_cnt   <= r_branch_cnt + 32'd1;
        if (w_redirect_evt) r_redirect_cnt <= r_redirect_cnt + 32'd1;
      end
    end
  end

  assign IF_flush_o     = r_if_flush;
  assign ID_flush_o     = r_id_flush;
  assign PC_redirect_o  = r_redirect;
  assign PC_target_o    = r_target;
  assign misalign_o     = r_misalign;
  assign misalign_pc_o  = r_misalign_pc;
  assign branch_cnt_o   = r_branch_cnt;
  assign redirect_cnt_o = r_redirect_cnt;

endmodule
